fib_checker: RTL and testbench

Streaming Fibonacci sequence checker, the consuming end of the Fibonacci generator stream. It accepts terms over a valid/ready handshake and compares each against an internally tracked expected term of the canonical sequence 0, 1, 1, 2, 3, 5, … It reports pass after N consecutive matching terms, or error with the failing index on a mismatch or width overflow. It sits downstream of the generator in self-checking benches and in the on-chip BIST path.

---
 rtl/fib_checker.sv | 132 +++++++++++++
 tb/tb_fib_checker.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_checker.sv
// fib_checker: streaming Fibonacci sequence checker.
//   Consumes terms over a valid/ready handshake and compares each against
//   the canonical sequence 0, 1, 1, 2, 3, 5, ... tracked internally.
//   Reports pass after N consecutive matches, or error with the failing
//   index on a mismatch or when the next expected term overflows WIDTH bits.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   start      begin a run (ignored while a run is in progress)
//   in_valid   in_data holds a term
//   in_data    term under test
//   in_ready   high only while running; decoded from registered state
//   done       run finished (sticky until start/rst)
//   pass       N terms matched (sticky)
//   err        mismatch or overflow (sticky)
//   ovf        error cause is overflow of the expected term
//   err_index  0-based index of the failing term
//   count      terms accepted and matched in this run
module fib_checker #(
    parameter int WIDTH = 32,
    parameter int N     = 10,
    localparam int CW   = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             done,
    output logic             pass,
    output logic             err,
    output logic             ovf,
    output logic [CW-1:0]    err_index,
    output logic [CW-1:0]    count
);

    typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

    localparam logic [CW-1:0] N_CW = CW'(N);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] exp_term, prev_term, exp_nxt, prev_nxt;
    logic [CW-1:0]    count_nxt, err_index_nxt, count_inc;
    logic             done_nxt, pass_nxt, err_nxt, ovf_nxt;
    logic [WIDTH:0]   sum;

    // Extra carry bit exposes overflow of the following expected term.
    assign sum       = {1'b0, exp_term} + {1'b0, prev_term};
    assign count_inc = count + 1'b1;
    assign in_ready  = (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            exp_term  <= '0;
            prev_term <= WIDTH'(1);
            count     <= '0;
            err_index <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            state     <= state_nxt;
            exp_term  <= exp_nxt;
            prev_term <= prev_nxt;
            count     <= count_nxt;
            err_index <= err_index_nxt;
            done      <= done_nxt;
            pass      <= pass_nxt;
            err       <= err_nxt;
            ovf       <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        exp_nxt       = exp_term;
        prev_nxt      = prev_term;
        count_nxt     = count;
        err_index_nxt = err_index;
        done_nxt      = done;
        pass_nxt      = pass;
        err_nxt       = err;
        ovf_nxt       = ovf;
        case (state)
            RUN: begin
                // start is deliberately ignored here; only rst aborts a run.
                if (in_valid) begin
                    if (in_data == exp_term) begin
                        count_nxt = count_inc;
                        exp_nxt   = sum[WIDTH-1:0];
                        prev_nxt  = exp_term;
                        // Reaching N wins over an overflow on the same term.
                        if (count_inc == N_CW) begin
                            state_nxt = DONE;
                            done_nxt  = 1'b1;
                            pass_nxt  = 1'b1;
                        end else if (sum[WIDTH]) begin
                            state_nxt     = ERR;
                            done_nxt      = 1'b1;
                            err_nxt       = 1'b1;
                            ovf_nxt       = 1'b1;
                            err_index_nxt = count_inc;
                        end
                    end else begin
                        state_nxt     = ERR;
                        done_nxt      = 1'b1;
                        err_nxt       = 1'b1;
                        err_index_nxt = count;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_nxt     = RUN;
                    exp_nxt       = '0;
                    prev_nxt      = WIDTH'(1);
                    count_nxt     = '0;
                    err_index_nxt = '0;
                    done_nxt      = 1'b0;
                    pass_nxt      = 1'b0;
                    err_nxt       = 1'b0;
                    ovf_nxt       = 1'b0;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_fib_checker.sv
// Bench for fib_checker: main instance (WIDTH=32, N=10) plus two 8-bit
// instances (N=16, N=14) that share the data stream for the overflow case.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_fib_checker;

    logic        clk = 1'b0;
    logic        rst, start, start8, in_valid;
    logic [31:0] in_data;

    logic       m_ready, m_done, m_pass, m_err, m_ovf;
    logic [3:0] m_eidx, m_count;
    logic       a_ready, a_done, a_pass, a_err, a_ovf;
    logic [4:0] a_eidx, a_count;
    logic       b_ready, b_done, b_pass, b_err, b_ovf;
    logic [3:0] b_eidx, b_count;

    // Status vectors: {done, pass, err, ovf, in_ready}
    wire [4:0] m_st = {m_done, m_pass, m_err, m_ovf, m_ready};
    wire [4:0] a_st = {a_done, a_pass, a_err, a_ovf, a_ready};
    wire [4:0] b_st = {b_done, b_pass, b_err, b_ovf, b_ready};

    localparam logic [4:0] ST_RUN  = 5'b00001;
    localparam logic [4:0] ST_PASS = 5'b11000;
    localparam logic [4:0] ST_MIS  = 5'b10100;
    localparam logic [4:0] ST_OVF  = 5'b10110;

    typedef struct packed {
        logic [4:0] st;
        logic [4:0] cnt;
        logic [4:0] eidx;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fib_checker #(.WIDTH(32), .N(10)) u_main (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(m_ready), .done(m_done), .pass(m_pass), .err(m_err), .ovf(m_ovf),
        .err_index(m_eidx), .count(m_count));

    fib_checker #(.WIDTH(8), .N(16)) u_ovf16 (
        .clk(clk), .rst(rst), .start(start8), .in_valid(in_valid), .in_data(in_data[7:0]),
        .in_ready(a_ready), .done(a_done), .pass(a_pass), .err(a_err), .ovf(a_ovf),
        .err_index(a_eidx), .count(a_count));

    fib_checker #(.WIDTH(8), .N(14)) u_ovf14 (
        .clk(clk), .rst(rst), .start(start8), .in_valid(in_valid), .in_data(in_data[7:0]),
        .in_ready(b_ready), .done(b_done), .pass(b_pass), .err(b_err), .ovf(b_ovf),
        .err_index(b_eidx), .count(b_count));

    function automatic logic [31:0] fib(input int i);
        logic [31:0] a, b, t;
        a = 0;
        b = 1;
        repeat (i) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({m_st, m_count, m_eidx} !== '0)
            begin failures++; $display("FAIL reset_main got st=%b cnt=%0d eidx=%0d exp all 0", m_st, m_count, m_eidx); end
        checks++;
        if ({a_st, a_count, a_eidx, b_st, b_count, b_eidx} !== '0)
            begin failures++; $display("FAIL reset_8bit got a_st=%b b_st=%b exp 0", a_st, b_st); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_st, m_count} !== '0)
            begin failures++; $display("FAIL idle_hold got st=%b cnt=%0d exp 0", m_st, m_count); end
    endtask

    task automatic test_pass();
        exp_t e;
        pulse_start();
        checks++;
        if (m_st !== ST_RUN || m_count !== 4'd0)
            begin failures++; $display("FAIL pass_start got st=%b cnt=%0d exp st=%b cnt=0", m_st, m_count, ST_RUN); end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = fib(i);
            sbq.push_back('{st: (i == 9) ? ST_PASS : ST_RUN, cnt: 5'(i + 1), eidx: 5'd0});
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if ({m_st, 5'(m_count), 5'(m_eidx)} !== e)
                begin failures++; $display("FAIL pass_term%0d got st=%b cnt=%0d eidx=%0d exp st=%b cnt=%0d eidx=%0d", i, m_st, m_count, m_eidx, e.st, e.cnt, e.eidx); end
        end
        in_data = fib(10);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (m_st !== ST_PASS || m_count !== 4'd10)
            begin failures++; $display("FAIL pass_extra got st=%b cnt=%0d exp st=%b cnt=10", m_st, m_count, ST_PASS); end
    endtask

    task automatic test_mismatch();
        exp_t        e;
        logic [31:0] t[5] = '{0, 1, 1, 2, 4};
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = t[i];
            if (i == 4) sbq.push_back('{st: ST_MIS, cnt: 5'd4, eidx: 5'd4});
            else        sbq.push_back('{st: ST_RUN, cnt: 5'(i + 1), eidx: 5'd0});
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if ({m_st, 5'(m_count), 5'(m_eidx)} !== e)
                begin failures++; $display("FAIL mismatch_term%0d got st=%b cnt=%0d eidx=%0d exp st=%b cnt=%0d eidx=%0d", i, m_st, m_count, m_eidx, e.st, e.cnt, e.eidx); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_overflow();
        exp_t ea, eb;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1;
            in_data  = fib(i);
            if (i == 13) begin
                sbq.push_back('{st: ST_OVF, cnt: 5'd14, eidx: 5'd14});
                sbq.push_back('{st: ST_PASS, cnt: 5'd14, eidx: 5'd0});
            end else begin
                sbq.push_back('{st: ST_RUN, cnt: 5'(i + 1), eidx: 5'd0});
                sbq.push_back('{st: ST_RUN, cnt: 5'(i + 1), eidx: 5'd0});
            end
            @(negedge clk);
            ea = sbq.pop_front();
            eb = sbq.pop_front();
            checks++;
            if ({a_st, a_count, a_eidx} !== ea)
                begin failures++; $display("FAIL ovf16_term%0d got st=%b cnt=%0d eidx=%0d exp st=%b cnt=%0d eidx=%0d", i, a_st, a_count, a_eidx, ea.st, ea.cnt, ea.eidx); end
            checks++;
            if ({b_st, 5'(b_count), 5'(b_eidx)} !== eb)
                begin failures++; $display("FAIL ovf14_term%0d got st=%b cnt=%0d eidx=%0d exp st=%b cnt=%0d eidx=%0d", i, b_st, b_count, b_eidx, eb.st, eb.cnt, eb.eidx); end
        end
        in_valid = 1'b0;
        checks++;
        if (m_st !== ST_MIS || m_count !== 4'd4)
            begin failures++; $display("FAIL err_sticky got st=%b cnt=%0d exp st=%b cnt=4", m_st, m_count, ST_MIS); end
    endtask

    task automatic test_gapped();
        exp_t e;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'd7;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({m_st, m_count} !== '0)
            begin failures++; $display("FAIL idle_valid got st=%b cnt=%0d exp st=0 cnt=0", m_st, m_count); end
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = fib(i);
            sbq.push_back('{st: (i == 9) ? ST_PASS : ST_RUN, cnt: 5'(i + 1), eidx: 5'd0});
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if ({m_st, 5'(m_count), 5'(m_eidx)} !== e)
                begin failures++; $display("FAIL gap_term%0d got st=%b cnt=%0d eidx=%0d exp st=%b cnt=%0d eidx=%0d", i, m_st, m_count, m_eidx, e.st, e.cnt, e.eidx); end
            in_valid = 1'b0;
            in_data  = 32'hdead_beef;
            @(negedge clk);
            checks++;
            if ({m_st, 5'(m_count), 5'(m_eidx)} !== e)
                begin failures++; $display("FAIL gap_hold%0d got st=%b cnt=%0d exp st=%b cnt=%0d", i, m_st, m_count, e.st, e.cnt); end
        end
    endtask

    task automatic test_reset_mid_run();
        exp_t e;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = fib(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (m_st !== ST_RUN || m_count !== 4'd5)
            begin failures++; $display("FAIL midrun_count got st=%b cnt=%0d exp st=%b cnt=5", m_st, m_count, ST_RUN); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({m_st, m_count, m_eidx} !== '0)
            begin failures++; $display("FAIL async_reset got st=%b cnt=%0d eidx=%0d exp all 0", m_st, m_count, m_eidx); end
        @(negedge clk);
        rst = 1'b0;
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = fib(i);
            sbq.push_back('{st: (i == 9) ? ST_PASS : ST_RUN, cnt: 5'(i + 1), eidx: 5'd0});
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if ({m_st, 5'(m_count), 5'(m_eidx)} !== e)
                begin failures++; $display("FAIL postrst_term%0d got st=%b cnt=%0d exp st=%b cnt=%0d", i, m_st, m_count, e.st, e.cnt); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_restart();
        exp_t e;
        // Restart from DONE, with a start pulse during RUN that must be ignored.
        pulse_start();
        checks++;
        if ({m_st, m_count, m_eidx} !== {ST_RUN, 8'd0})
            begin failures++; $display("FAIL restart_done got st=%b cnt=%0d exp st=%b cnt=0", m_st, m_count, ST_RUN); end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = fib(i);
            start    = (i == 3);
            sbq.push_back('{st: (i == 9) ? ST_PASS : ST_RUN, cnt: 5'(i + 1), eidx: 5'd0});
            @(negedge clk);
            start = 1'b0;
            e = sbq.pop_front();
            checks++;
            if ({m_st, 5'(m_count), 5'(m_eidx)} !== e)
                begin failures++; $display("FAIL restart_term%0d got st=%b cnt=%0d exp st=%b cnt=%0d", i, m_st, m_count, e.st, e.cnt); end
        end
        in_valid = 1'b0;
        // Force an error at index 1, then restart from ERR.
        pulse_start();
        in_valid = 1'b1;
        in_data  = 32'd0;
        @(negedge clk);
        in_data  = 32'd5;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({m_st, m_count, m_eidx} !== {ST_MIS, 4'd1, 4'd1})
            begin failures++; $display("FAIL err_idx1 got st=%b cnt=%0d eidx=%0d exp st=%b cnt=1 eidx=1", m_st, m_count, m_eidx, ST_MIS); end
        pulse_start();
        checks++;
        if ({m_st, m_count, m_eidx} !== {ST_RUN, 8'd0})
            begin failures++; $display("FAIL restart_err got st=%b cnt=%0d eidx=%0d exp st=%b cnt=0 eidx=0", m_st, m_count, m_eidx, ST_RUN); end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = fib(i);
            sbq.push_back('{st: (i == 9) ? ST_PASS : ST_RUN, cnt: 5'(i + 1), eidx: 5'd0});
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if ({m_st, 5'(m_count), 5'(m_eidx)} !== e)
                begin failures++; $display("FAIL rerun_term%0d got st=%b cnt=%0d exp st=%b cnt=%0d", i, m_st, m_count, e.st, e.cnt); end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        start8   = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        test_reset();
        test_pass();
        test_mismatch();
        test_overflow();
        test_gapped();
        test_reset_mid_run();
        test_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
